seq_detect_scheduler: RTL

Time-shares one overlapping "1010" Mealy detection function across NCH independent serial bit streams. A round-robin arbiter accepts at most one bit per cycle. Each channel keeps its own saved detector state (context). The block emits a one-cycle match pulse tagged with the channel number and keeps a saturating match count per channel. It sits between the serial front-end requesters and the status/CSR logic.

---
 rtl/seq_detect_pkg.sv | 30 +++
 rtl/seq_detect_scheduler_if.sv | 30 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/seq_detect_scheduler.sv | 92 +++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the time-shared overlapping "1010" Mealy detector.
//   state_t    : 2-bit per-channel detector context
//   next_state : context transition on one accepted bit
//   mealy_out  : match output for (context, bit)
package seq_detect_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S0 = 2'd0;  // idle
   localparam state_t S1 = 2'd1;  // seen "1"
   localparam state_t S2 = 2'd2;  // seen "10"
   localparam state_t S3 = 2'd3;  // seen "101"

   function automatic state_t next_state(input state_t i_state, input logic i_x);
      state_t w_ns;
      case (i_state)
         S0:      w_ns = i_x ? S1 : S0;
         S1:      w_ns = i_x ? S1 : S2;
         S2:      w_ns = i_x ? S3 : S0;
         S3:      w_ns = i_x ? S1 : S2;  // "1010" keeps its trailing "10"
         default: w_ns = S0;
      endcase
      return w_ns;
   endfunction

   function automatic logic mealy_out(input state_t i_state, input logic i_x);
      return (i_state == S3) && !i_x;
   endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Bus between the serial front-end/CSR side and seq_detect_scheduler.
//   master : requesters and CSR logic (drive bits, flush, clear, counter select)
//   slave  : the scheduler (drives grants, match pulse, counter readout)
interface seq_detect_scheduler_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
);
   localparam int CH_W = $clog2(NCH);

   logic             enable;
   logic [NCH-1:0]   bit_valid;
   logic [NCH-1:0]   bit_data;
   logic [NCH-1:0]   bit_ready;
   logic [NCH-1:0]   chan_flush;
   logic             clr_cnt;
   logic             match_valid;
   logic [CH_W-1:0]  match_ch;
   logic [CH_W-1:0]  cnt_sel;
   logic [CNT_W-1:0] cnt_out;

   modport master (
      output enable, bit_valid, bit_data, chan_flush, clr_cnt, cnt_sel,
      input  bit_ready, match_valid, match_ch, cnt_out
   );

   modport slave (
      input  enable, bit_valid, bit_data, chan_flush, clr_cnt, cnt_sel,
      output bit_ready, match_valid, match_ch, cnt_out
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping modulo NCH; the pointer moves past the winner on a grant.
//   clk, reset  : clock, asynchronous active-high reset (pointer -> 0)
//   i_req       : per-requester request
//   o_gnt       : one-hot grant (all-zero when nothing requests)
//   o_gnt_idx   : index of the granted requester
//   o_gnt_any   : a grant is issued this cycle
module rr_arbiter #(
   parameter  int NCH  = 4,
   localparam int CH_W = $clog2(NCH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NCH-1:0]  i_req,
   output logic [NCH-1:0]  o_gnt,
   output logic [CH_W-1:0] o_gnt_idx,
   output logic            o_gnt_any
);

   logic [CH_W-1:0] r_ptr;
   int              w_cand;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_any = 1'b0;
      w_cand    = 0;
      for (int k = 0; k < NCH; k++) begin
         w_cand = (int'(r_ptr) + k) % NCH;
         if (!o_gnt_any && i_req[w_cand]) begin
            o_gnt_any        = 1'b1;
            o_gnt_idx        = CH_W'(w_cand);
            o_gnt[w_cand]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (o_gnt_any) begin
         r_ptr <= (o_gnt_idx == CH_W'(NCH - 1)) ? '0 : o_gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One "1010" overlapping Mealy detector time-shared across NCH serial
// channels. Each channel keeps its own saved context; a round-robin arbiter
// accepts at most one bit per cycle. Matches give a registered one-cycle pulse
// tagged with the channel and bump a saturating per-channel counter.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of seq_detect_scheduler_if (bits/grants, flush,
//                counter clear/readout, match pulse)
module seq_detect_scheduler
   import seq_detect_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int CNT_W = 8,
   localparam int CH_W  = $clog2(NCH)
) (
   input logic                  clk,
   input logic                  reset,
   seq_detect_scheduler_if.slave bus
);

   state_t           r_ctx [NCH];
   logic [CNT_W-1:0] r_cnt [NCH];
   logic             r_match_valid;
   logic [CH_W-1:0]  r_match_ch;

   logic [NCH-1:0]   w_req;
   logic [NCH-1:0]   w_gnt;
   logic [CH_W-1:0]  w_gnt_idx;
   logic             w_gnt_any;
   logic             w_hit;

   // Flushing channels are kept off the arbiter so their bit stays pending;
   // reset also masks requests so no grant is visible while it is held.
   assign w_req = bus.bit_valid & ~bus.chan_flush & {NCH{bus.enable & ~reset}};

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_req     (w_req),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_any (w_gnt_any)
   );

   assign w_hit = w_gnt_any && mealy_out(r_ctx[w_gnt_idx], bus.bit_data[w_gnt_idx]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) r_ctx[i] <= S0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.chan_flush[i]) begin
               r_ctx[i] <= S0;
            end else if (w_gnt[i]) begin
               r_ctx[i] <= next_state(r_ctx[i], bus.bit_data[i]);
            end
         end
      end
   end

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.clr_cnt) begin
               r_cnt[i] <= '0;
            end else if (w_hit && w_gnt[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_match_valid <= 1'b0;
         r_match_ch    <= '0;
      end else begin
         r_match_valid <= w_hit;
         if (w_hit) r_match_ch <= w_gnt_idx;
      end
   end

   assign bus.bit_ready   = w_gnt;
   assign bus.match_valid = r_match_valid;
   assign bus.match_ch    = r_match_ch;
   assign bus.cnt_out     = r_cnt[bus.cnt_sel];

endmodule
